// File: rtl/alu_seq_slice_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_slice_pkg
// Description : Shared constants for the nibble-sliced sequential ALU:
//               nibble width, FSM state encoding and named function selects.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_slice_pkg;

  // Width of one lookahead slice
  localparam int NIB_W = 4;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Frequently used function selects (m=0)
  localparam logic [3:0] S_ADD = 4'b1001;  // A + B + c0
  localparam logic [3:0] S_SUB = 4'b0110;  // A + ~B + c0

endpackage : alu_seq_slice_pkg
`default_nettype wire

// File: rtl/alu_seq_slice_nibble.sv
`default_nettype none
// ============================================================================
// Module      : alu_nibble
// Description : Combinational 4-bit ALU slice with internal carry lookahead.
//               Exposes the carry into bit 3 so the top can form signed
//               overflow on the most significant slice.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_nibble
  import alu_seq_slice_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic [NIB_W-1:0] f,
  output logic             cout,
  output logic             c3
);

  logic [NIB_W-1:0] w_x;
  logic [NIB_W-1:0] w_y;
  logic [NIB_W-1:0] w_g;
  logic [NIB_W-1:0] w_p;
  logic [NIB_W:0]   w_c;

  // Per-bit X/Y terms, generate/propagate and flattened lookahead carries
  always_comb begin
    w_x = ~(a | (b & {NIB_W{s[0]}}) | (~b & {NIB_W{s[1]}}));
    w_y = ~((a & b & {NIB_W{s[3]}}) | (a & ~b & {NIB_W{s[2]}}));
    w_g = ~w_y;
    w_p = ~w_x;

    w_c[0] = cin;
    w_c[1] = w_g[0] | (w_p[0] & cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & cin);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    // Logic mode (m=1) masks the carries out of the sum
    f = w_x ^ w_y ^ ({NIB_W{~m}} & w_c[NIB_W-1:0]);
  end

  assign cout = w_c[4];
  assign c3   = w_c[3];

endmodule : alu_nibble
`default_nettype wire

// File: rtl/alu_seq_slice.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_slice
// Description : Multi-cycle ALU. Operands are captured on start, then SPC
//               nibble slices are evaluated per cycle (LSB group first) with
//               the group carry rippled through a register. Result, active-
//               low carry-out, all-ones compare and signed overflow are
//               presented with a one-cycle done pulse and held afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_slice
  import alu_seq_slice_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             ci_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             co_n,
  output logic             aeqb,
  output logic             ovf
);

  localparam int GW    = NIB_W * SPC;            // bits handled per cycle
  localparam int NG    = WIDTH / GW;             // cycles per operation
  localparam int IDX_W = (NG > 1) ? $clog2(NG) : 1;
  localparam int SH_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NG - 1);

  // FSM state
  logic [0:0]       r_state;
  logic [0:0]       w_state_next;

  // Captured operation
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_s;
  logic             r_m;

  // Sequencing and results
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_y;
  logic             r_done;
  logic             r_co_n;
  logic             r_aeqb;
  logic             r_ovf;

  // Current-group datapath
  logic [SH_W-1:0]  w_base;
  logic [GW-1:0]    w_a_grp;
  logic [GW-1:0]    w_b_grp;
  logic [GW-1:0]    w_f_grp;
  logic [SPC:0]     w_c;
  logic [SPC-1:0]   w_c3;
  logic [WIDTH-1:0] w_y_next;
  logic             w_last;
  logic             w_accept;

  // Select the operand bits of the group under evaluation and merge its result
  always_comb begin
    w_base   = SH_W'(int'(r_idx) * GW);
    w_a_grp  = r_a[w_base +: GW];
    w_b_grp  = r_b[w_base +: GW];
    w_y_next = r_y;
    w_y_next[w_base +: GW] = w_f_grp;
    w_last   = (r_idx == LAST_IDX);
    w_accept = (r_state == ST_IDLE) && start;
  end

  assign w_c[0] = r_carry;

  // SPC slices chained combinationally within one cycle
  generate
    for (genvar k = 0; k < SPC; k++) begin : g_nib
      alu_nibble u_nib (
        .a    (w_a_grp[k*NIB_W +: NIB_W]),
        .b    (w_b_grp[k*NIB_W +: NIB_W]),
        .s    (r_s),
        .m    (r_m),
        .cin  (w_c[k]),
        .f    (w_f_grp[k*NIB_W +: NIB_W]),
        .cout (w_c[k+1]),
        .c3   (w_c3[k])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE waits for start, RUN leaves after the last group
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_IDLE;
      default:             w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (r_state == ST_RUN);
  end

  // Operand capture, per-group evaluation and completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
      r_co_n  <= 1'b1;
      r_aeqb  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_s     <= s;
        r_m     <= m;
        r_carry <= ~ci_n;
        r_idx   <= '0;
      end else if (r_state == ST_RUN) begin
        r_y     <= w_y_next;
        r_carry <= w_c[SPC];
        r_idx   <= r_idx + IDX_W'(1);
        if (w_last) begin
          // Final group: c_WIDTH is the group carry-out, c_(WIDTH-1) the
          // carry into bit 3 of the top slice
          r_idx  <= '0;
          r_done <= 1'b1;
          r_co_n <= r_m | ~w_c[SPC];
          r_ovf  <= ~r_m & (w_c[SPC] ^ w_c3[SPC-1]);
          r_aeqb <= &w_y_next;
        end
      end
    end
  end

  assign done = r_done;
  assign y    = r_y;
  assign co_n = r_co_n;
  assign aeqb = r_aeqb;
  assign ovf  = r_ovf;

endmodule : alu_seq_slice
`default_nettype wire

// File: tb/tb_alu_seq_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_slice
// Description : Self-checking bench for alu_seq_slice. Two instances are
//               exercised: 16-bit with one slice per cycle and 32-bit with
//               two slices per cycle. Results are compared against a word-
//               level arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_slice;
  import alu_seq_slice_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [31:0] a, b;
  logic [3:0]  s;
  logic        m, ci_n;

  logic        busy0, done0, co_n0, aeqb0, ovf0;
  logic [15:0] y0;
  logic        busy1, done1, co_n1, aeqb1, ovf1;
  logic [31:0] y1;

  int n_vec  = 0;
  int n_fail = 0;

  alu_seq_slice #(.WIDTH(16), .SPC(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a[15:0]), .b(b[15:0]), .s(s),
    .m(m), .ci_n(ci_n), .busy(busy0), .done(done0), .y(y0), .co_n(co_n0),
    .aeqb(aeqb0), .ovf(ovf0)
  );

  alu_seq_slice #(.WIDTH(32), .SPC(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .s(s),
    .m(m), .ci_n(ci_n), .busy(busy1), .done(done1), .y(y1), .co_n(co_n1),
    .aeqb(aeqb1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  // One comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: generate word G and propagate word P (G implies P
  // bitwise), so the arithmetic result is simply G + P + c0 and the logic
  // result is G ^ P.
  function automatic void model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                input logic [3:0] ts, input logic tm, input logic tci,
                                output logic [63:0] ey, output logic eco_n,
                                output logic eovf, output logic eaeqb);
    logic [63:0] msk, lmsk, g, p, sum, low, c0;
    msk  = (64'd1 << w) - 64'd1;
    lmsk = (64'd1 << (w - 1)) - 64'd1;
    g    = {32'd0, ta & ((tb & {32{ts[3]}}) | (~tb & {32{ts[2]}}))} & msk;
    p    = {32'd0, ta | (tb & {32{ts[0]}}) | (~tb & {32{ts[1]}})} & msk;
    c0   = {63'd0, ~tci};
    if (tm) begin
      ey    = g ^ p;
      eco_n = 1'b1;
      eovf  = 1'b0;
    end else begin
      sum   = g + p + c0;
      low   = (g & lmsk) + (p & lmsk) + c0;
      ey    = sum & msk;
      eco_n = ~sum[w];
      eovf  = sum[w] ^ low[w-1];
    end
    eaeqb = (ey == msk);
  endfunction

  // Launch one operation from a negedge, wait for done (bounded) and check.
  // poke >= 0 re-pulses start with scrambled inputs after that many RUN cycles.
  // Returns at the negedge where done is observed.
  task automatic run_op(input int which, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [3:0] ts, input logic tm, input logic tci, input int poke);
    int          w, lat, ncyc;
    logic [63:0] ey;
    logic        eco_n, eovf, eaeqb, dn;
    w    = which ? 32 : 16;
    ncyc = which ? 4 : 4;
    model(w, ta, tb, ts, tm, tci, ey, eco_n, eovf, eaeqb);
    a = ta; b = tb; s = ts; m = tm; ci_n = tci;
    if (which != 0) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    check("busy_after_start", which ? busy1 : busy0, 64'd1);
    lat = 0;
    dn  = which ? done1 : done0;
    while (!dn && lat < 12) begin
      if (lat == poke) begin
        a = $urandom; b = $urandom; s = 4'($urandom); m = ~m; ci_n = ~ci_n;
        if (which != 0) start1 = 1'b1; else start0 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      lat++;
      dn = which ? done1 : done0;
    end
    check("latency", 64'(lat), 64'(ncyc));
    check("y",    which ? 64'(y1) : 64'(y0), ey);
    check("co_n", which ? co_n1 : co_n0, eco_n);
    check("ovf",  which ? ovf1 : ovf0, eovf);
    check("aeqb", which ? aeqb1 : aeqb0, eaeqb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    logic [3:0] rs;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; ci_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy0, 64'd0);
    check("rst_done", done0, 64'd0);
    check("rst_y",    64'(y0), 64'd0);
    check("rst_co_n", co_n0, 64'd1);
    check("rst_aeqb", aeqb0, 64'd0);
    check("rst_ovf",  ovf0, 64'd0);
    check("rst_busy1", busy1, 64'd0);
    check("rst_y1",   64'(y1), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plain add
    run_op(0, 32'h1234, 32'h0FFF, S_ADD, 1'b0, 1'b1, -1);
    check("t1_y_const", 64'(y0), 64'h2233);
    @(negedge clk);
    check("done_pulse_len", done0, 64'd0);
    check("y_held", 64'(y0), 64'h2233);

    // Subtract with borrow, then a start coincident with done
    run_op(0, 32'h0005, 32'h0007, S_SUB, 1'b0, 1'b0, -1);
    check("sub_borrow_y", 64'(y0), 64'hFFFE);
    run_op(0, 32'h0007, 32'h0005, S_SUB, 1'b0, 1'b0, -1);
    check("sub_noborrow_co_n", co_n0, 64'd0);

    // Equality via A - B - 1 = all ones
    run_op(0, 32'hBEEF, 32'hBEEF, S_SUB, 1'b0, 1'b1, -1);
    check("aeqb_equal", aeqb0, 64'd1);
    run_op(0, 32'hBEEF, 32'hBEEE, S_SUB, 1'b0, 1'b1, -1);

    // Signed overflow and logic mode
    run_op(0, 32'h7FFF, 32'h0001, S_ADD, 1'b0, 1'b1, -1);
    check("ovf_const", ovf0, 64'd1);
    run_op(0, 32'hF0F0, 32'hFF00, S_ADD, 1'b1, 1'b1, -1);
    check("xor_const", 64'(y0), 64'h0FF0);

    // start and input changes during RUN are ignored
    run_op(0, 32'h1234, 32'h0FFF, S_ADD, 1'b0, 1'b1, 1);
    check("poke_y_const", 64'(y0), 64'h2233);

    // Reset in the middle of RUN abandons the operation
    @(negedge clk);
    a = 32'hAAAA; b = 32'h5555; s = S_ADD; m = 1'b0; ci_n = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy0, 64'd0);
    check("midrst_done", done0, 64'd0);
    check("midrst_y",    64'(y0), 64'd0);
    check("midrst_co_n", co_n0, 64'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0) seen++;
    end
    check("no_done_after_rst", 64'(seen), 64'd0);

    // Wider instance, two slices per cycle
    run_op(1, 32'h1234, 32'h0FFF, S_ADD, 1'b0, 1'b1, -1);
    check("w32_y_const", 64'(y1), 64'h2233);
    run_op(1, 32'h89ABCDEF, 32'h76543211, S_ADD, 1'b0, 1'b1, -1);
    run_op(1, 32'h7FFFFFFF, 32'h00000001, S_ADD, 1'b0, 1'b1, -1);
    run_op(1, 32'hBEEFCAFE, 32'hBEEFCAFE, S_SUB, 1'b0, 1'b1, 1);

    // Randomised operations on both instances
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = S_ADD;
        1:       rs = S_SUB;
        default: rs = 4'($urandom);
      endcase
      run_op(i % 2, $urandom, $urandom, rs, ($urandom_range(0, 2) == 0),
             1'($urandom), (($urandom_range(0, 3) == 0) ? 1 : -1));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_alu_seq_slice
`default_nettype wire
